// File: rtl/adc_eth_packetizer_if.sv
// Byte-wide AXI-Stream link from the packetizer toward the Ethernet MAC/UDP wrapper.
//   m_tdata  : stream byte
//   m_tvalid : byte valid
//   m_tready : sink ready
//   m_tlast  : last byte of frame
// master drives data/valid/last; slave drives ready.
interface adc_eth_packetizer_if;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic       m_tlast;

  modport master (
    output m_tdata,
    output m_tvalid,
    output m_tlast,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tvalid,
    input  m_tlast,
    output m_tready
  );
endinterface

// File: rtl/adc_eth_packetizer.sv
// adc_eth_packetizer: collects FIFO-controller words into two ping-pong frame banks and
// emits each closed bank as a byte-wide AXI-Stream frame with an 8-byte header
// (MAGIC, chan, seq hi/lo, count hi/lo, 00, 00) followed by big-endian payload words.
// Upstream is never stalled; words arriving while both banks are busy are dropped.
//
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   in_valid       : in_chan/in_data qualifier
//   in_chan[2:0]   : source channel of the word
//   in_data[15:0]  : sample word
//   m_axis         : AXI-Stream master (m_tdata, m_tvalid, m_tready, m_tlast)
//   overflow       : sticky, set on any dropped word
//   dropped_words  : saturating dropped-word count
//
// Optional feature: define PKT_CHECKSUM_EN to append a 16-bit big-endian sum of the
// payload words after the payload; m_tlast then marks the second checksum byte.
module adc_eth_packetizer #(
  parameter int unsigned WORDS_PER_FRAME = 1024,
  parameter logic [7:0]  MAGIC           = 8'hAD
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [2:0]                  in_chan,
  input  logic [15:0]                 in_data,
  adc_eth_packetizer_if.master        m_axis,
  output logic                        overflow,
  output logic [15:0]                 dropped_words
);

  localparam int unsigned AW      = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  localparam logic [15:0] LastIdx = 16'(WORDS_PER_FRAME - 1);
  localparam logic [AW-1:0] LastAddr = AW'(WORDS_PER_FRAME - 1);

  typedef enum logic [1:0] {BFree, BFill, BReady, BSend} bank_st_e;
  typedef enum logic [1:0] {WIdle, WFill, WDrop} wr_st_e;
`ifdef PKT_CHECKSUM_EN
  typedef enum logic [1:0] {RIdle, RHdr, RPay, RSum} rd_st_e;
`else
  typedef enum logic [1:0] {RIdle, RHdr, RPay} rd_st_e;
`endif

  logic [15:0] mem [2][WORDS_PER_FRAME];

  // Per-bank bookkeeping
  bank_st_e    bank_st_q [2];
  bank_st_e    bank_st_d [2];
  logic [2:0]  bank_chan_q [2];
  logic [2:0]  bank_chan_d [2];
  logic [15:0] bank_cnt_q [2];
  logic [15:0] bank_cnt_d [2];
  logic        first_q, first_d;  // bank that closed first when both are ready

  // Write side
  wr_st_e      wr_st_q, wr_st_d;
  logic        wr_bank_q, wr_bank_d;
  logic [15:0] wr_idx_q, wr_idx_d;
  logic        have_free, free_bank, chan_chg;
  logic        open, close, drop, fill_wr;
  logic [15:0] close_cnt;
  logic        mem_we, mem_wbank;
  logic [AW-1:0] mem_waddr;

  // Read side
  rd_st_e      rd_st_q, rd_st_d;
  logic        rd_bank_q, rd_bank_d;
  logic [2:0]  hdr_idx_q, hdr_idx_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic        half_q, half_d;  // 0: MSB byte of the current word, 1: LSB byte
  logic [15:0] seq_q, seq_d;
  logic [7:0]  lsb_q, lsb_d;
  logic [15:0] rd_word_q;
  logic        rd_load;
  logic [AW-1:0] rd_addr;
  logic        rdy0, rdy1, any_ready, rd_sel, rd_start, hs, last_word, pay_end, frame_done;
`ifdef PKT_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
`endif

  // ---------------- write-side decode ----------------
  assign have_free = (bank_st_q[0] == BFree) || (bank_st_q[1] == BFree);
  assign free_bank = (bank_st_q[0] == BFree) ? 1'b0 : 1'b1;
  assign chan_chg  = in_chan != bank_chan_q[wr_bank_q];
  // A channel change in WFill closes the bank and re-enters the idle decision this cycle.
  assign open      = in_valid && have_free &&
                     ((wr_st_q == WIdle) || ((wr_st_q == WFill) && chan_chg));
  assign drop      = in_valid && (((wr_st_q == WIdle) && !have_free) ||
                                  ((wr_st_q == WFill) && chan_chg && !have_free) ||
                                  (wr_st_q == WDrop));
  assign fill_wr   = (wr_st_q == WFill) && in_valid && !chan_chg;
  assign close     = (wr_st_q == WFill) && (!in_valid || chan_chg || (wr_idx_q == LastIdx));
  assign close_cnt = fill_wr ? wr_idx_q + 16'd1 : wr_idx_q;

  // ---------------- read-side decode ----------------
  assign rdy0       = bank_st_q[0] == BReady;
  assign rdy1       = bank_st_q[1] == BReady;
  assign any_ready  = rdy0 || rdy1;
  assign rd_sel     = (rdy0 && rdy1) ? first_q : rdy1;
  assign rd_start   = (rd_st_q == RIdle) && any_ready;
  assign hs         = (rd_st_q != RIdle) && m_axis.m_tready;
  assign last_word  = word_idx_q == (bank_cnt_q[rd_bank_q] - 16'd1);
  assign pay_end    = (rd_st_q == RPay) && hs && half_q && last_word;
`ifdef PKT_CHECKSUM_EN
  assign frame_done = (rd_st_q == RSum) && hs && half_q;
`else
  assign frame_done = pay_end;
`endif

  // ---------------- state registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        bank_st_q[b]   <= BFree;
        bank_chan_q[b] <= '0;
        bank_cnt_q[b]  <= '0;
      end
      first_q       <= 1'b0;
      wr_st_q       <= WIdle;
      wr_bank_q     <= 1'b0;
      wr_idx_q      <= '0;
      rd_st_q       <= RIdle;
      rd_bank_q     <= 1'b0;
      hdr_idx_q     <= '0;
      word_idx_q    <= '0;
      half_q        <= 1'b0;
      seq_q         <= '0;
      lsb_q         <= '0;
`ifdef PKT_CHECKSUM_EN
      sum_q         <= '0;
`endif
      overflow      <= 1'b0;
      dropped_words <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        bank_st_q[b]   <= bank_st_d[b];
        bank_chan_q[b] <= bank_chan_d[b];
        bank_cnt_q[b]  <= bank_cnt_d[b];
      end
      first_q    <= first_d;
      wr_st_q    <= wr_st_d;
      wr_bank_q  <= wr_bank_d;
      wr_idx_q   <= wr_idx_d;
      rd_st_q    <= rd_st_d;
      rd_bank_q  <= rd_bank_d;
      hdr_idx_q  <= hdr_idx_d;
      word_idx_q <= word_idx_d;
      half_q     <= half_d;
      seq_q      <= seq_d;
      lsb_q      <= lsb_d;
`ifdef PKT_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
      if (drop) begin
        overflow <= 1'b1;
        if (dropped_words != 16'hFFFF) dropped_words <= dropped_words + 16'd1;
      end
    end
  end

  // Bank RAM: one write port, one registered read port.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wbank][mem_waddr] <= in_data;
    if (rd_load) rd_word_q <= mem[rd_bank_q][rd_addr];
  end

  // ---------------- write FSM: next state ----------------
  always_comb begin
    wr_st_d = wr_st_q;
    unique case (wr_st_q)
      WIdle: begin
        if (open)      wr_st_d = WFill;
        else if (drop) wr_st_d = WDrop;
      end
      WFill: begin
        if (open)       wr_st_d = WFill;
        else if (drop)  wr_st_d = WDrop;
        else if (close) wr_st_d = WIdle;
      end
      WDrop: begin
        if (!in_valid) wr_st_d = WIdle;
      end
      default: wr_st_d = WIdle;
    endcase
  end

  // ---------------- write FSM: outputs ----------------
  always_comb begin
    mem_we    = open || fill_wr;
    mem_wbank = open ? free_bank : wr_bank_q;
    mem_waddr = open ? '0 : wr_idx_q[AW-1:0];
    wr_bank_d = open ? free_bank : wr_bank_q;
    wr_idx_d  = wr_idx_q;
    if (open)         wr_idx_d = 16'd1;
    else if (fill_wr) wr_idx_d = wr_idx_q + 16'd1;
  end

  // ---------------- bank bookkeeping (write and read touch disjoint states) -------
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_st_d[b]   = bank_st_q[b];
      bank_chan_d[b] = bank_chan_q[b];
      bank_cnt_d[b]  = bank_cnt_q[b];
    end
    first_d = first_q;
    if (close) begin
      bank_st_d[wr_bank_q]  = BReady;
      bank_cnt_d[wr_bank_q] = close_cnt;
      if (bank_st_q[~wr_bank_q] != BReady) first_d = wr_bank_q;
    end
    if (open) begin
      bank_st_d[free_bank]   = BFill;
      bank_chan_d[free_bank] = in_chan;
    end
    if (rd_start)   bank_st_d[rd_sel]    = BSend;
    if (frame_done) bank_st_d[rd_bank_q] = BFree;
  end

  // ---------------- read FSM: next state ----------------
  always_comb begin
    rd_st_d = rd_st_q;
    unique case (rd_st_q)
      RIdle: if (any_ready) rd_st_d = RHdr;
      RHdr:  if (hs && (hdr_idx_q == 3'd7)) rd_st_d = RPay;
`ifdef PKT_CHECKSUM_EN
      RPay:  if (pay_end) rd_st_d = RSum;
      RSum:  if (frame_done) rd_st_d = RIdle;
`else
      RPay:  if (pay_end) rd_st_d = RIdle;
`endif
      default: rd_st_d = RIdle;
    endcase
  end

  // ---------------- read datapath ----------------
  // While in RPay, the RAM is read at word_idx+1 on the MSB handshake (the LSB byte is
  // parked in lsb_q), so the next word is already in rd_word_q when the LSB byte retires.
  always_comb begin
    rd_bank_d  = rd_bank_q;
    hdr_idx_d  = hdr_idx_q;
    word_idx_d = word_idx_q;
    half_d     = half_q;
    seq_d      = seq_q;
    lsb_d      = lsb_q;
    rd_load    = 1'b0;
    rd_addr    = '0;
`ifdef PKT_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    unique case (rd_st_q)
      RIdle: begin
        hdr_idx_d = '0;
        if (any_ready) rd_bank_d = rd_sel;
      end
      RHdr: begin
        rd_load    = 1'b1;
        word_idx_d = '0;
        half_d     = 1'b0;
`ifdef PKT_CHECKSUM_EN
        sum_d      = '0;
`endif
        if (hs) hdr_idx_d = hdr_idx_q + 3'd1;
      end
      RPay: begin
        rd_addr = (word_idx_q[AW-1:0] == LastAddr) ? '0 : word_idx_q[AW-1:0] + AW'(1);
        if (hs) begin
          if (!half_q) begin
            half_d  = 1'b1;
            lsb_d   = rd_word_q[7:0];
            rd_load = 1'b1;
`ifdef PKT_CHECKSUM_EN
            sum_d   = sum_q + rd_word_q;
`endif
          end else begin
            half_d = 1'b0;
            if (!last_word) word_idx_d = word_idx_q + 16'd1;
          end
        end
      end
`ifdef PKT_CHECKSUM_EN
      RSum: if (hs) half_d = ~half_q;
`endif
      default: ;
    endcase
    if (frame_done) seq_d = seq_q + 16'd1;
  end

  // ---------------- read FSM: outputs ----------------
  always_comb begin
    m_axis.m_tvalid = rd_st_q != RIdle;
    m_axis.m_tdata  = '0;
    m_axis.m_tlast  = 1'b0;
    unique case (rd_st_q)
      RHdr: begin
        case (hdr_idx_q)
          3'd0:    m_axis.m_tdata = MAGIC;
          3'd1:    m_axis.m_tdata = {5'b0, bank_chan_q[rd_bank_q]};
          3'd2:    m_axis.m_tdata = seq_q[15:8];
          3'd3:    m_axis.m_tdata = seq_q[7:0];
          3'd4:    m_axis.m_tdata = bank_cnt_q[rd_bank_q][15:8];
          3'd5:    m_axis.m_tdata = bank_cnt_q[rd_bank_q][7:0];
          default: m_axis.m_tdata = 8'h00;
        endcase
      end
      RPay: begin
        m_axis.m_tdata = half_q ? lsb_q : rd_word_q[15:8];
`ifndef PKT_CHECKSUM_EN
        m_axis.m_tlast = half_q && last_word;
`endif
      end
`ifdef PKT_CHECKSUM_EN
      RSum: begin
        m_axis.m_tdata = half_q ? sum_q[7:0] : sum_q[15:8];
        m_axis.m_tlast = half_q;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_adc_eth_packetizer.sv
module tb_adc_eth_packetizer;

`ifdef PKT_CHECKSUM_EN
  localparam int CS = 2;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  in_chan;
  logic [15:0] in_data;
  logic        overflow;
  logic [15:0] dropped_words;

  adc_eth_packetizer_if axis ();

  adc_eth_packetizer dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_chan       (in_chan),
    .in_data       (in_data),
    .m_axis        (axis),
    .overflow      (overflow),
    .dropped_words (dropped_words)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int proto_err = 0;

  logic [7:0] rx_bytes[$];
  int         rx_lens[$];

  // Stream monitor: captures handshaked bytes and checks the AXI-Stream rules.
  int         cur_len = 0;
  logic       in_frame = 1'b0, after_last = 1'b0;
  logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      cur_len = 0; in_frame = 1'b0; after_last = 1'b0; prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready &&
          (!axis.m_tvalid || axis.m_tdata != prev_data || axis.m_tlast != prev_last))
        proto_err++;
      if (in_frame && !axis.m_tvalid) proto_err++;
      if (after_last && axis.m_tvalid) proto_err++;
      after_last = 1'b0;
      if (axis.m_tvalid && axis.m_tready) begin
        rx_bytes.push_back(axis.m_tdata);
        cur_len++;
        if (axis.m_tlast) begin
          rx_lens.push_back(cur_len);
          cur_len = 0; in_frame = 1'b0; after_last = 1'b1;
        end else begin
          in_frame = 1'b1;
        end
      end
      prev_valid = axis.m_tvalid; prev_ready = axis.m_tready;
      prev_data  = axis.m_tdata;  prev_last  = axis.m_tlast;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive_word(input logic [2:0] c, input logic [15:0] d);
    @(posedge clk); #1;
    in_valid = 1'b1; in_chan = c; in_data = d;
  endtask

  task automatic drive_idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_burst(input logic [2:0] c, input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) drive_word(c, base + 16'(i));
    drive_idle();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rx_bytes.delete();
    rx_lens.delete();
  endtask

  task automatic wait_frames(input string name, input int n, input int budget);
    int t = 0;
    while (rx_lens.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (rx_lens.size() < n) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: got %0d frames expected %0d", name, rx_lens.size(), n);
    end
    repeat (4) @(posedge clk);
  endtask

  // Pops one received frame and compares it with a model-built frame whose payload
  // words are base, base+1, ...
  task automatic check_frame(input string name, input logic [63:0] exp_hdr,
                             input logic [15:0] base, input int nwords, input int exp_len);
    logic [7:0]  got[$];
    logic [7:0]  exp_b[$];
    logic [63:0] hdr;
    logic [15:0] w, sum;
    int          len, bad;
    if (rx_lens.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s frame: got 0 frames expected 1", name);
      return;
    end
    len = rx_lens.pop_front();
    for (int i = 0; i < len && rx_bytes.size() > 0; i++) got.push_back(rx_bytes.pop_front());
    chk({name, " length"}, 64'(len), 64'(exp_len));
    hdr = '0;
    for (int i = 0; i < 8; i++) hdr = {hdr[55:0], (i < got.size()) ? got[i] : 8'h00};
    chk({name, " header"}, hdr, exp_hdr);
    sum = '0;
    for (int i = 0; i < nwords; i++) begin
      w = base + 16'(i);
      sum = sum + w;
      exp_b.push_back(w[15:8]);
      exp_b.push_back(w[7:0]);
    end
`ifdef PKT_CHECKSUM_EN
    exp_b.push_back(sum[15:8]);
    exp_b.push_back(sum[7:0]);
`endif
    bad = 0;
    for (int i = 0; i < exp_b.size(); i++) begin
      if (8 + i >= got.size()) bad++;
      else if (got[8 + i] !== exp_b[i]) bad++;
    end
    chk({name, " payload byte errors"}, 64'(bad), 64'd0);
  endtask

  typedef struct {
    int          nwords;
    logic [2:0]  chan;
    logic [15:0] base;
    logic [63:0] exp_hdr;
    int          exp_len;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int t;
    vecs[0] = '{1024, 3'd2, 16'h0000, 64'hAD02_0000_0400_0000, 2056 + CS};
    vecs[1] = '{10,   3'd5, 16'h1234, 64'hAD05_0001_000A_0000, 28 + CS};
    vecs[2] = '{2,    3'd7, 16'hFFFF, 64'hAD07_0002_0002_0000, 12 + CS};
    vecs[3] = '{1,    3'd0, 16'hBEEF, 64'hAD00_0003_0001_0000, 10 + CS};

    rst = 1'b1; in_valid = 1'b0; in_chan = '0; in_data = '0; axis.m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset tvalid/tlast", {axis.m_tvalid, axis.m_tlast}, 64'd0);
    chk("reset tdata", axis.m_tdata, 64'd0);
    chk("reset overflow/dropped", {overflow, dropped_words}, 64'd0);
    rst = 1'b0;

    // Table: bursts closed by word limit or by in_valid falling, seq running 0..3.
    for (int v = 0; v < 4; v++) begin
      drive_burst(vecs[v].chan, vecs[v].nwords, vecs[v].base);
      wait_frames($sformatf("vec%0d", v), 1, 5000);
      check_frame($sformatf("vec%0d", v), vecs[v].exp_hdr, vecs[v].base,
                  vecs[v].nwords, vecs[v].exp_len);
    end

    // Channel change inside a contiguous burst.
    do_reset();
    for (int i = 0; i < 5; i++) drive_word(3'd0, 16'h0100 + 16'(i));
    for (int i = 0; i < 3; i++) drive_word(3'd1, 16'h0200 + 16'(i));
    drive_idle();
    wait_frames("chg", 2, 2000);
    check_frame("chg f1", 64'hAD00_0000_0005_0000, 16'h0100, 5, 18 + CS);
    check_frame("chg f2", 64'hAD01_0001_0003_0000, 16'h0200, 3, 14 + CS);
    chk("chg overflow", overflow, 64'd0);

    // Backpressure: third burst finds both banks occupied and is dropped.
    do_reset();
    axis.m_tready = 1'b0;
    drive_burst(3'd3, 1024, 16'h0000);
    drive_burst(3'd3, 1024, 16'h4000);
    drive_burst(3'd3, 1024, 16'h8000);
    repeat (4) @(posedge clk);
    #1;
    chk("bp overflow", overflow, 64'd1);
    chk("bp dropped_words", dropped_words, 64'd1024);
    chk("bp bytes while stalled", 64'(rx_bytes.size()), 64'd0);
    axis.m_tready = 1'b1;
    wait_frames("bp", 2, 10000);
    check_frame("bp f1", 64'hAD03_0000_0400_0000, 16'h0000, 1024, 2056 + CS);
    check_frame("bp f2", 64'hAD03_0001_0400_0000, 16'h4000, 1024, 2056 + CS);
    chk("bp no extra frame", 64'(rx_lens.size()), 64'd0);

    // Reset in the middle of a frame's payload.
    do_reset();
    drive_burst(3'd4, 200, 16'h5000);
    t = 0;
    while (rx_bytes.size() < 108 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("rst reached 108 bytes", 64'(rx_bytes.size() >= 108), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst tvalid drops", axis.m_tvalid, 64'd0);
    chk("rst no tlast seen", 64'(rx_lens.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rx_bytes.delete();
    rx_lens.delete();
    drive_burst(3'd4, 10, 16'h6000);
    wait_frames("post-rst", 1, 2000);
    check_frame("post-rst", 64'hAD04_0000_000A_0000, 16'h6000, 10, 28 + CS);

    // Words 1..4: checksum 000A when enabled; tlast on byte 18, else byte 16.
    drive_burst(3'd0, 4, 16'h0001);
    wait_frames("sum", 1, 2000);
    check_frame("sum", 64'hAD00_0001_0004_0000, 16'h0001, 4, 16 + CS);

    chk("stream protocol violations", 64'(proto_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_eth_packetizer.md
# adc_eth_packetizer

Downstream neighbour of the FIFO read controller. Collects words qualified by `in_valid` and produced by the six channel FIFOs (the FIFO output mux selected by the controller's `addr`) into ping-pong frame buffers. Emits each buffered burst as a byte-wide AXI-Stream frame with an 8-byte header toward the Ethernet MAC/UDP wrapper. Upstream cannot be stalled, so the block absorbs the controller's 1024-word bursts and drops words only when both banks are occupied.

## Interface
- `WORDS_PER_FRAME`, 1024: max payload words per frame; legal range 2..32768.
- `MAGIC`, 8'hAD: first header byte.

- `clk`  in  1  single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `eth_en` delayed by the FIFO read latency; `in_data`/`in_chan` are valid when high.
- `in_chan`  in  3  source FIFO index (controller `addr`, equally delayed).
- `in_data`  in  16  sample word.
- `m_tdata`  out  8  stream byte.
- `m_tvalid`  out  1  stream valid.
- `m_tready`  in  1  MAC ready.
- `m_tlast`  out  1  last byte of frame.
- `overflow`  out  1  sticky; set on any dropped word.
- `dropped_words`  out  16  count of dropped words; saturates at 16'hFFFF.

## Operation
- **Storage:** two banks, each `WORDS_PER_FRAME` x 16. Per bank: state (free / filling / ready / sending), channel, word count.
- **Write FSM**
  - W_IDLE: on `in_valid`=1 with a free bank, write the word at index 0, latch `in_chan`, go to W_FILL. With no free bank, drop the word and go to W_DROP.
  - W_FILL closes the bank (bank becomes ready, FSM returns to W_IDLE) when any of these occurs:
    - `in_valid`=0: the frame holds the words received so far.
    - The word at index `WORDS_PER_FRAME-1` is written: that word is included.
    - `in_valid`=1 with `in_chan` different from the latched channel: the bank closes and this word is treated exactly as in W_IDLE in the same cycle.
  - W_DROP: every word with `in_valid`=1 is dropped. Return to W_IDLE on `in_valid`=0.
  - A dropped word sets `overflow` and increments `dropped_words`.
- **Read FSM:** R_IDLE → R_HDR → R_PAY [→ R_SUM] → R_IDLE.
  - Ready banks are served in close order (oldest first).
  - Header bytes: `MAGIC`, {5'b0, chan}, seq[15:8], seq[7:0], count[15:8], count[7:0], 8'h00, 8'h00.
  - Payload: each word big-endian (MSB byte first), in word order.
  - `m_tlast` is high on the final byte of the frame only. The bank becomes free on the handshake of that byte.
- **Sequence number:** 16-bit. Increments by 1 after each frame's last handshake and wraps 16'hFFFF → 0.
- A zero-length frame is never emitted.
- **Reset mid-operation:** both banks free, both FSMs idle, the in-flight frame is abandoned with no `m_tlast`. Reset values: seq=0, `overflow`=0, `dropped_words`=0.

## Timing
- Reset values: `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `overflow`=0, `dropped_words`=0.
- Write acceptance: one word per cycle, zero stall, no backpressure to upstream.
- Bank close happens at the clock edge that samples the closing condition. With `m_tready`=1 and the read side idle, the first header byte appears on `m_tvalid` no later than 2 cycles after that edge.
- AXI-Stream rules:
  - `m_tdata`/`m_tlast` stay stable while `m_tvalid`=1 and `m_tready`=0.
  - `m_tvalid` never drops before the handshake.
  - Within a frame, `m_tvalid` stays high from the first header byte through the `m_tlast` byte. No bubbles; the bank RAM read is prefetched one cycle ahead.
- Between frames at least 1 idle cycle (`m_tvalid`=0).
- A bank freed on a handshake edge is available to the write FSM in the following cycle.
- Throughput: a full 1024-word frame is 2056 bytes (2058 with checksum). This fits inside the controller's 1024 + 8192-cycle burst period at `m_tready`=1.

## Configuration
- `PKT_CHECKSUM_EN` defined:
  - After the payload, the read FSM enters R_SUM and emits a 16-bit modulo-2^16 sum of all payload words, big-endian.
  - `m_tlast` moves to the second checksum byte.
  - The header count is unchanged (payload words only).
- Undefined: R_SUM and the accumulator are absent, and `m_tlast` is on the last payload byte.

## Test plan
- **Full burst:** 1024 consecutive words, chan=2, data=index 0..1023, `m_tready`=1 → one 2056-byte frame.
  - Header AD 02 00 00 04 00 00 00.
  - Payload 00 00 00 01 … 03 FF, `m_tlast` on byte 2056 only.
- **Short burst:** 10 words, then `in_valid`=0 → frame with count bytes 00 0A and 28 bytes total, seq=0.
- **Channel change:** 5 words on chan 0, then 3 words on chan 1 contiguous → two frames.
  - Frame 1: chan 00, count 5, seq 0.
  - Frame 2: chan 01, count 3, seq 1.
  - No word lost, `overflow`=0.
- **Backpressure and drop:** `m_tready`=0, three 1024-word bursts separated by 1 idle cycle.
  - Third burst dropped; `overflow`=1, `dropped_words`=1024.
  - Release `m_tready` → exactly two frames, seq 0 and 1, data intact.
- **Reset mid-frame:** assert `rst` after 100 payload bytes → `m_tvalid`=0 immediately. Next burst emits seq=0.
- **Checksum (with `PKT_CHECKSUM_EN`):** words 1,2,3,4 → payload followed by 00 0A, `m_tlast` on byte 18. Without the macro, `m_tlast` is on byte 16.
